// File: rtl/alpide_pwr_seq.sv
// alpide_pwr_seq: sequences the ALPIDE control-pin front-end through OFF, ZERO, RESET, SETTLE, READY.
module alpide_pwr_seq #(
    parameter int ZERO_CYCLES   = 16,
    parameter int RST_CYCLES    = 64,
    parameter int SETTLE_CYCLES = 256,
    parameter int CW            = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_on_i,
    input  logic       cmd_off_i,
    input  logic       cmd_reset_i,
    input  logic       alpide_phase_i,
    input  logic       dctrl_oe_i,
    output logic       oe_o,
    output logic       rst_o,
    output logic       forcezero_o,
    output logic       dctrl_oe_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        OFF    = 3'd0,
        ZERO   = 3'd1,
        RESET  = 3'd2,
        SETTLE = 3'd3,
        READY  = 3'd4
    } state_t;
    localparam logic [CW-1:0] ZERO_LAST   = CW'(ZERO_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          timed;
    assign timed = busy_o;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= OFF;
            cnt    <= '0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= (state_nxt != state) ? '0 : (timed && !(&cnt)) ? cnt + 1'b1 : cnt;
            done_o <= (state_nxt == READY) && (state != READY);
        end
    end
    // Phased exits wait for alpide_phase_i so the pins change on an MCLK-aligned edge.
    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (cmd_on_i) state_nxt = ZERO;
            ZERO:    if (cnt >= ZERO_LAST && alpide_phase_i) state_nxt = RESET;
            RESET:   if (cnt >= RST_LAST && alpide_phase_i) state_nxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_nxt = READY;
            READY:   if (cmd_reset_i) state_nxt = RESET;
            default: state_nxt = OFF;
        endcase
        if (cmd_off_i) state_nxt = OFF;
    end
    assign state_o     = state;
    assign oe_o        = state != OFF;
    assign forcezero_o = (state == OFF) || (state == ZERO);
    assign rst_o       = (state == OFF) || (state == ZERO) || (state == RESET);
    assign ready_o     = state == READY;
    assign busy_o      = (state == ZERO) || (state == RESET) || (state == SETTLE);
    assign dctrl_oe_o  = dctrl_oe_i & ready_o;
endmodule

// File: tb/tb_alpide_pwr_seq.sv
// tb_alpide_pwr_seq: vector table, hand-written sequences and random stimulus against a cycle model.
module tb_alpide_pwr_seq;
    localparam int Z = 4, R = 8, S = 16;
    logic       clk = 0;
    logic       rst_n_i = 0, cmd_on_i = 0, cmd_off_i = 0, cmd_reset_i = 0;
    logic       alpide_phase_i = 0, dctrl_oe_i = 0;
    logic       oe_o, rst_o, forcezero_o, dctrl_oe_o, ready_o, busy_o, done_o;
    logic [2:0] state_o;
    int         tests = 0, fails = 0;
    int         ms = 0, mage = 0;
    logic       mdone = 0;
    logic       ph = 1, dc = 1;

    alpide_pwr_seq #(.ZERO_CYCLES(Z), .RST_CYCLES(R), .SETTLE_CYCLES(S), .CW(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .cmd_on_i(cmd_on_i), .cmd_off_i(cmd_off_i),
        .cmd_reset_i(cmd_reset_i), .alpide_phase_i(alpide_phase_i), .dctrl_oe_i(dctrl_oe_i),
        .oe_o(oe_o), .rst_o(rst_o), .forcezero_o(forcezero_o), .dctrl_oe_o(dctrl_oe_o),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Reference: how long each phase lasts, and what each command does, from the rules alone.
    function automatic int model_next(input logic on, off, rc, p);
        int base [5] = '{0, Z, R, S, 0};
        if (off) return 0;
        if (ms == 0) return on ? 1 : 0;
        if (ms == 4) return rc ? 2 : 4;
        if (ms == 3) return (mage == S - 1) ? 4 : 3;
        return (mage >= base[ms] - 1 && p) ? ms + 1 : ms;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic on, off, rc, d, rn, p);
        int nx;
        logic [9:0] expv, actv;
        cmd_on_i = on; cmd_off_i = off; cmd_reset_i = rc;
        dctrl_oe_i = d; rst_n_i = rn; alpide_phase_i = p;
        nx = !rn ? 0 : model_next(on, off, rc, p);
        @(posedge clk);
        #1;
        mdone = rn && nx == 4 && ms != 4;
        mage  = (!rn || nx != ms) ? 0 : mage + 1;
        ms    = nx;
        expv = {3'(ms), ms != 0, ms <= 1, ms <= 2, ms == 4, ms >= 1 && ms <= 3, mdone,
                dctrl_oe_i && ms == 4};
        actv = {state_o, oe_o, forcezero_o, rst_o, ready_o, busy_o, done_o, dctrl_oe_o};
        chk("model_outputs", int'(actv), int'(expv));
    endtask

    task automatic cyc(input logic on, off, rc);
        apply(on, off, rc, dc, 1'b1, ph);
        ph = ~ph;
    endtask

    task automatic measure(input int st, lo, hi, input bit need_ph, input int inj);
        int   n = 0;
        logic lp = 0;
        while (state_o == 3'(st) && n < 40) begin
            n++;
            lp = ph;
            cyc(1'b0, 1'b0, n == inj);
        end
        tests++;
        if (n < lo || n > hi) begin
            fails++;
            $display("FAIL duration of state %0d: got %0d cycles, expected %0d..%0d", st, n, lo, hi);
        end
        if (need_ph) chk("exit_phase", int'(lp), 1);
        chk("exit_state", int'(state_o), st + 1);
    endtask

    task automatic power_up(input int inj);
        cyc(1'b1, 1'b0, 1'b0);
        chk("enter_zero", int'(state_o), 1);
        measure(1, Z, Z + 1, 1'b1, 0);
        measure(2, R, R + 1, 1'b1, 0);
        measure(3, S, S, 1'b0, inj);
        chk("done_first_ready", int'(done_o), 1);
    endtask

    typedef struct {
        logic on, off, rc;
        logic [2:0] st;
        logic oe, fz, rs;
    } vec_t;
    vec_t tbl [9];

    initial begin
        tbl[0] = '{0, 0, 0, 3'd0, 0, 1, 1};
        tbl[1] = '{1, 1, 0, 3'd0, 0, 1, 1};
        tbl[2] = '{1, 0, 0, 3'd1, 1, 1, 1};
        tbl[3] = '{0, 0, 1, 3'd1, 1, 1, 1};
        tbl[4] = '{1, 0, 0, 3'd1, 1, 1, 1};
        tbl[5] = '{0, 1, 0, 3'd0, 0, 1, 1};
        tbl[6] = '{0, 0, 1, 3'd0, 0, 1, 1};
        tbl[7] = '{1, 0, 0, 3'd1, 1, 1, 1};
        tbl[8] = '{1, 1, 0, 3'd0, 0, 1, 1};

        for (int i = 0; i < 3; i++) apply(0, 0, 0, dc, 0, ph);
        for (int i = 0; i < 50; i++) cyc(0, 0, 0);
        chk("idle_state", int'(state_o), 0);
        chk("idle_pins", int'({oe_o, forcezero_o, rst_o, ready_o, busy_o}), 5'b01100);

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].on, tbl[i].off, tbl[i].rc);
            chk($sformatf("vec%0d_state", i), int'(state_o), int'(tbl[i].st));
            chk($sformatf("vec%0d_pins", i), int'({oe_o, forcezero_o, rst_o}),
                int'({tbl[i].oe, tbl[i].fz, tbl[i].rs}));
            chk($sformatf("vec%0d_dctrl", i), int'(dctrl_oe_o), 0);
        end

        power_up(0);
        cyc(0, 0, 0);
        chk("done_one_cycle", int'(done_o), 0);
        dctrl_oe_i = 0; dc = 0;
        #1 chk("dctrl_follow_low", int'(dctrl_oe_o), 0);
        dctrl_oe_i = 1; dc = 1;
        #1 chk("dctrl_follow_high", int'(dctrl_oe_o), 1);

        cyc(0, 0, 1);
        chk("reset_cmd_ready", int'(state_o), 2);
        measure(2, R, R + 1, 1'b1, 0);
        measure(3, S, S, 1'b0, 5);
        chk("done_second", int'(done_o), 1);

        cyc(0, 1, 0);
        chk("off_from_ready", int'(state_o), 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("off_from_zero", int'(state_o), 0);
        cyc(1, 0, 0);
        measure(1, Z, Z + 1, 1'b1, 0);
        measure(2, R, R + 1, 1'b1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("off_from_settle", int'(state_o), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1);
        chk("off_stays", int'(state_o), 0);

        cyc(1, 0, 0);
        measure(1, Z, Z + 1, 1'b1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        chk("mid_reset_in_reset", int'(state_o), 2);
        apply(0, 0, 0, dc, 0, ph);
        ph = ~ph;
        chk("mid_reset_state", int'(state_o), 0);
        chk("mid_reset_pins", int'({oe_o, forcezero_o, rst_o}), 3'b011);
        power_up(0);

        for (int i = 0; i < 3000; i++)
            apply($urandom_range(7) == 0, $urandom_range(39) == 0, $urandom_range(9) == 0,
                  1'($urandom), $urandom_range(199) != 0, 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alpide_pwr_seq.md
Name: alpide_pwr_seq

Overview:
- Sequences the ALPIDE control-pin front-end through power-on, forced-zero, reset and ready phases.
- Drives the front-end's output-enable, reset and force-zero controls.
- Gates the host's DCTRL output-enable so the bus is only driven while the chip is ready.
- Sits between the host command registers and the ALPIDE IO front-end, in the same clock domain.

Parameters:
- ZERO_CYCLES, 16, clk_i cycles pins are held at forced zero after enable (>=1)
- RST_CYCLES, 64, clk_i cycles reset is asserted with clock running (>=1)
- SETTLE_CYCLES, 256, clk_i cycles waited after reset release before READY (>=1)
- CW, 16, counter width; every *_CYCLES value must be <= 2**CW

Ports:
- clk_i  in  1  system clock (twice the ALPIDE MCLK rate)
- rst_n_i  in  1  synchronous reset, active-low
- cmd_on_i  in  1  single-cycle pulse: start power-up sequence
- cmd_off_i  in  1  single-cycle pulse: return to OFF
- cmd_reset_i  in  1  single-cycle pulse: re-reset the chip from READY
- alpide_phase_i  in  1  MCLK phase from the IO front-end; transitions are aligned to phase=1
- dctrl_oe_i  in  1  host request to drive DCTRL
- oe_o  out  1  to the front-end output-enable
- rst_o  out  1  to the front-end reset (active-high)
- forcezero_o  out  1  to the front-end force-zero
- dctrl_oe_o  out  1  gated DCTRL output-enable
- ready_o  out  1  high in READY
- busy_o  out  1  high in ZERO, RESET and SETTLE
- done_o  out  1  one-cycle pulse on entry to READY
- state_o  out  3  encoded state: OFF=0, ZERO=1, RESET=2, SETTLE=3, READY=4

Behaviour:
- Outputs are Moore outputs decoded from the registered state. done_o is registered.
- Reset (rst_n_i=0 at a clk_i edge): state=OFF, counter=0, done_o=0.
- Output values per state (oe/forcezero/rst):
  - OFF: 0/1/1
  - ZERO: 1/1/1
  - RESET: 1/0/1
  - SETTLE: 1/0/0
  - READY: 1/0/0
- dctrl_oe_o = dctrl_oe_i & (state==READY). This term is combinational from dctrl_oe_i.
- Counter: cleared on every state entry, increments each cycle while in a timed state, and saturates at 2**CW-1.
- Transitions:
  - OFF -> ZERO on cmd_on_i.
  - ZERO -> RESET when counter>=ZERO_CYCLES-1 and alpide_phase_i=1.
  - RESET -> SETTLE when counter>=RST_CYCLES-1 and alpide_phase_i=1.
  - SETTLE -> READY when counter==SETTLE_CYCLES-1. This transition has no phase requirement.
  - READY -> RESET on cmd_reset_i.
- Command priority: cmd_off_i takes OFF from any state, next cycle. It overrides cmd_on_i, cmd_reset_i and timed transitions in the same cycle.
- Ignored commands:
  - cmd_on_i outside OFF.
  - cmd_reset_i outside READY. This includes pulses during SETTLE.
- Phase alignment: a phased state lasts its base count, or its base count +1 when the phase is wrong at expiry. It never lasts longer than base +1, given the front-end toggles the phase every cycle.
- done_o pulses for exactly one cycle, in the first cycle state_o=READY.
- Mid-operation reset:
  - Reset asserted mid-sequence returns to OFF in the next cycle.
  - oe_o drops to 0 together with forcezero_o rising to 1. No glitch states are permitted.

Test Plan (bench uses ZERO=4, RST=8, SETTLE=16, phase toggling every cycle):
- Reset release, no commands -> state_o=0, oe_o=0, forcezero_o=1, rst_o=1, ready_o=0, busy_o=0 for 50 cycles.
- cmd_on_i pulse -> ZERO for 4–5 cycles, RESET for 8–9 cycles with forcezero_o=0 and rst_o=1, then SETTLE for exactly 16 cycles with rst_o=0. Then READY with a single done_o pulse. Exits from ZERO and RESET occur only on alpide_phase_i=1.
- In READY, cmd_reset_i pulse -> RESET next cycle. Repeat the RESET/SETTLE timing and expect a second done_o pulse. Also: cmd_reset_i pulsed during SETTLE -> no effect.
- cmd_off_i asserted in ZERO, in SETTLE and in READY (separately), and cmd_off_i together with cmd_on_i in OFF -> OFF next cycle in each case; in OFF, stays OFF.
- dctrl_oe_i held at 1 throughout the sequence -> dctrl_oe_o=0 except in READY, where it follows dctrl_oe_i with zero latency.
- rst_n_i low for 1 cycle during RESET at counter=3 -> OFF with outputs 0/1/1. A subsequent cmd_on_i runs the full sequence from a zero count.
